gpio_checker: RTL and testbench

- Synthesizable self-checking monitor for the CPU `gpio` bus; replaces fixed-cycle sampling in benches with event-driven checking.
- Holds an ordered list of expected values. Each time `gpio` changes, the new value is compared against the next list entry.
- Reports pass/fail with the failing index and values, and flags a stall if no change occurs within a timeout.
- Sits beside `cpu`, driven by the same clock. Usable in simulation and on board (status driven to LEDs).

---
 rtl/gpio_checker.sv | 182 ++++++++++++++++++
 tb/tb_gpio_checker.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_checker.sv
`timescale 1ns/1ps
// Event-driven checker for the CPU gpio bus: each gpio change is compared with the next expected entry.
// Define GPIO_CHECKER_MASK_EN to add a per-entry compare mask (exp_mask) written alongside exp_data.
module gpio_checker #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 32,
   parameter int TIMEOUT    = 256,
   localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] gpio,
   input  logic                  exp_we,
   input  logic [AW-1:0]         exp_addr,
   input  logic [DATA_WIDTH-1:0] exp_data,
`ifdef GPIO_CHECKER_MASK_EN
   input  logic [DATA_WIDTH-1:0] exp_mask,
`endif
   input  logic [AW:0]           num_checks,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic                  fail,
   output logic                  stall,
   output logic [AW-1:0]         fail_index,
   output logic [DATA_WIDTH-1:0] fail_expected,
   output logic [DATA_WIDTH-1:0] fail_actual,
   output logic [1:0]            dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [DATA_WIDTH-1:0] exp_mem [DEPTH];
`ifdef GPIO_CHECKER_MASK_EN
   logic [DATA_WIDTH-1:0] mask_mem [DEPTH];
`endif

   logic [DATA_WIDTH-1:0] gpio_q;
   logic [DATA_WIDTH-1:0] exp_cur;
   logic [AW-1:0]         idx;
   logic [AW:0]           count;
   logic [TW-1:0]         timer;
   logic                  gpio_event;
   logic                  match;
   logic                  last_entry;
   logic                  timed_out;
   logic                  run_pass;
   logic                  run_fail;
   logic                  run_stall;

   assign exp_cur    = exp_mem[idx];
   assign gpio_event = (gpio != gpio_q);
`ifdef GPIO_CHECKER_MASK_EN
   // Event detection above stays full-width; only the comparison is masked.
   assign match      = (((gpio ^ exp_cur) & mask_mem[idx]) == '0);
`else
   assign match      = (gpio == exp_cur);
`endif
   assign last_entry = ({1'b0, idx} == (count - 1'b1));
   assign timed_out  = (timer == TW'(TIMEOUT - 1));
   assign busy       = (state_q == RUN);
   assign dbg_state  = state_q;

   // Expected list is only writable outside a run and is never cleared by reset.
   always_ff @(posedge clk) begin
      if (exp_we && (state_q != RUN)) begin
         exp_mem[exp_addr] <= exp_data;
`ifdef GPIO_CHECKER_MASK_EN
         mask_mem[exp_addr] <= exp_mask;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      run_pass  = 1'b0;
      run_fail  = 1'b0;
      run_stall = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = (num_checks == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (gpio_event) begin
               if (!match) begin
                  run_fail = 1'b1;
                  state_d  = DONE;
               end else if (last_entry) begin
                  run_pass = 1'b1;
                  state_d  = DONE;
               end
            end else if (timed_out) begin
               run_fail  = 1'b1;
               run_stall = 1'b1;
               state_d   = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gpio_q        <= '0;
         idx           <= '0;
         timer         <= '0;
         count         <= '0;
         done          <= 1'b0;
         pass          <= 1'b0;
         fail          <= 1'b0;
         stall         <= 1'b0;
         fail_index    <= '0;
         fail_expected <= '0;
         fail_actual   <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  count         <= num_checks;
                  gpio_q        <= gpio;
                  idx           <= '0;
                  timer         <= '0;
                  done          <= (num_checks == '0);
                  pass          <= (num_checks == '0);
                  fail          <= 1'b0;
                  stall         <= 1'b0;
                  fail_index    <= '0;
                  fail_expected <= '0;
                  fail_actual   <= '0;
               end
            end
            RUN: begin
               gpio_q <= gpio;
               if (run_pass || run_fail) begin
                  done <= 1'b1;
               end
               if (run_pass) begin
                  pass <= 1'b1;
               end
               if (run_fail) begin
                  fail       <= 1'b1;
                  fail_index <= idx;
               end
               // A stall reports the last value seen; a mismatch reports the offending value.
               if (run_stall) begin
                  stall       <= 1'b1;
                  fail_actual <= gpio_q;
               end else if (run_fail) begin
                  fail_expected <= exp_cur;
                  fail_actual   <= gpio;
               end
               if (gpio_event && match && !last_entry) begin
                  idx   <= idx + 1'b1;
                  timer <= '0;
               end else if (!gpio_event) begin
                  timer <= timer + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_checker.sv
`timescale 1ns/1ps
// Bench for gpio_checker: directed and random runs scored against a gpio-trace reference model.
module tb_gpio_checker;

   localparam int DW      = 32;
   localparam int DEPTH   = 32;
   localparam int TIMEOUT = 8;
   localparam int AW      = $clog2(DEPTH);
   localparam int EW      = 3 + AW + 2 * DW + 12;
   localparam int MAXS    = 80;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [DW-1:0] gpio = '0;
   logic          exp_we = 1'b0;
   logic [AW-1:0] exp_addr = '0;
   logic [DW-1:0] exp_data = '0;
   logic [DW-1:0] exp_mask = '1;
   logic [AW:0]   num_checks = '0;
   logic          busy, done, pass, fail, stall;
   logic [AW-1:0] fail_index;
   logic [DW-1:0] fail_expected, fail_actual;
   logic [1:0]    dbg_state;

   gpio_checker #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .start(start), .gpio(gpio),
      .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
`ifdef GPIO_CHECKER_MASK_EN
      .exp_mask(exp_mask),
`endif
      .num_checks(num_checks), .busy(busy), .done(done), .pass(pass), .fail(fail),
      .stall(stall), .fail_index(fail_index), .fail_expected(fail_expected),
      .fail_actual(fail_actual), .dbg_state(dbg_state)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- run description and scoreboard ----------------
   logic [DW-1:0] exp_list [DEPTH];
   logic [DW-1:0] mask_list [DEPTH];
   logic [DW-1:0] step_val [MAXS];
   int            step_hold [MAXS];
   int            nsteps;
   logic [EW-1:0] exp_q [$];
   int            vectors = 0;
   int            miscompares = 0;
   int            runs_started = 0;
   int            runs_checked = 0;
   int            start_cyc = 0;

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] required);
      vectors++;
      if (actual !== required) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, actual, required, cyc);
      end
   endtask

   task automatic report();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   endtask

   function automatic logic [EW-1:0] pack(input logic p, input logic f, input logic st, input int k,
                                          input logic [DW-1:0] ex, input logic [DW-1:0] ac, input int e);
      return {p, f, st, AW'(k), ex, ac, 12'(e)};
   endfunction

   // Walks the gpio trace edge by edge: every change consumes the next list entry,
   // TIMEOUT consecutive unchanged samples end the run as a stall.
   function automatic logic [EW-1:0] model(input int n, input logic [DW-1:0] g0);
      logic [DW-1:0] prev, v;
      int k, quiet, e, reps;
      if (n == 0) return pack(1'b1, 1'b0, 1'b0, 0, '0, '0, 0);
      prev = g0; k = 0; quiet = 0; e = 0;
      for (int s = 0; s <= nsteps; s++) begin
         v    = (s < nsteps) ? step_val[s] : prev;
         reps = (s < nsteps) ? step_hold[s] : TIMEOUT + 1;
         for (int r = 0; r < reps; r++) begin
            e++;
            if (v != prev) begin
               if (((v ^ exp_list[k]) & mask_list[k]) == '0) begin
                  k++;
                  quiet = 0;
                  if (k == n) return pack(1'b1, 1'b0, 1'b0, 0, '0, '0, e);
               end else begin
                  return pack(1'b0, 1'b1, 1'b0, k, exp_list[k], v, e);
               end
            end else begin
               quiet++;
               if (quiet == TIMEOUT) return pack(1'b0, 1'b1, 1'b1, k, '0, prev, e);
            end
            prev = v;
         end
      end
      return '0;
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (reset && (runs_checked < runs_started) && done) begin
         if (exp_q.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("pass",          64'(pass),          64'(e[12+2*DW+AW+2]));
            check("fail",          64'(fail),          64'(e[12+2*DW+AW+1]));
            check("stall",         64'(stall),         64'(e[12+2*DW+AW]));
            check("fail_index",    64'(fail_index),    64'(e[12+2*DW +: AW]));
            check("fail_expected", 64'(fail_expected), 64'(e[12+DW +: DW]));
            check("fail_actual",   64'(fail_actual),   64'(e[12 +: DW]));
            check("latency",       64'(cyc - start_cyc), 64'(e[11:0]));
            check("busy_at_done",  64'(busy),          64'd0);
         end
         runs_checked++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic load_list(input int n);
      for (int i = 0; i < n; i++) begin
         exp_we = 1'b1; exp_addr = AW'(i); exp_data = exp_list[i]; exp_mask = mask_list[i];
         @(posedge clk); #1;
      end
      exp_we = 1'b0;
   endtask

   task automatic do_run(input int n, input logic [DW-1:0] g0, input bit disturb);
      logic [EW-1:0] expected;
      expected = model(n, g0);
      gpio = g0; num_checks = (AW+1)'(n); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      exp_q.push_back(expected);
      start_cyc = cyc;
      runs_started++;
      check("busy_after_start", 64'(busy), 64'(n != 0));
      if (n != 0) begin
         for (int s = 0; s < nsteps; s++) begin
            gpio = step_val[s];
            if (disturb && s == 1) begin
               exp_we = 1'b1; exp_addr = AW'(1); exp_data = ~exp_list[1];
               num_checks = '0; start = 1'b1;
            end
            for (int r = 0; r < step_hold[s]; r++) begin
               @(posedge clk); #1;
               exp_we = 1'b0; start = 1'b0;
            end
         end
      end
      for (int w = 0; w < TIMEOUT + 20 && runs_checked < runs_started; w++) begin
         @(posedge clk); #1;
      end
      if (runs_checked < runs_started) begin
         check("done_timeout", 64'd0, 64'd1);
         report();
      end
   endtask

   task automatic plan_list();
      exp_list[0] = 32'hFFFFFFFF; exp_list[1] = 32'h00000001; exp_list[2] = 32'h00000006;
      exp_list[3] = 32'h00000007; exp_list[4] = 32'hFFFFFF00;
      for (int i = 0; i < 5; i++) begin
         step_val[i] = exp_list[i]; step_hold[i] = 3;
      end
      nsteps = 5;
   endtask

   task automatic random_run();
      int n, r;
      logic [DW-1:0] g0, last;
      n = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
         exp_list[i] = $urandom;
         if (i > 0 && exp_list[i] == exp_list[i-1]) exp_list[i] = ~exp_list[i];
      end
      g0 = (n > 0) ? ~exp_list[0] : $urandom;
      last = g0;
      for (int i = 0; i < n; i++) begin
         r = $urandom_range(0, 19);
         if (r < 16) begin
            step_val[i] = exp_list[i]; step_hold[i] = $urandom_range(1, 4);
         end else if (r < 18) begin
            step_val[i] = $urandom; step_hold[i] = $urandom_range(1, 3);
         end else begin
            step_val[i] = last; step_hold[i] = $urandom_range(TIMEOUT, TIMEOUT + 2);
         end
         last = step_val[i];
      end
      nsteps = n;
      load_list(n);
      do_run(n, g0, 1'b0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      for (int i = 0; i < DEPTH; i++) mask_list[i] = '1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_pass", 64'(pass), 64'd0);
      check("rst_fail", 64'(fail), 64'd0);
      check("rst_stall", 64'(stall), 64'd0);
      check("rst_fail_index", 64'(fail_index), 64'd0);
      check("rst_fail_expected", 64'(fail_expected), 64'd0);
      check("rst_fail_actual", 64'(fail_actual), 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // full match, then a mismatch on the third value
      plan_list();
      load_list(5);
      do_run(5, '0, 1'b0);
      step_val[2] = 32'h00000005;
      do_run(5, '0, 1'b0);

      // stall after the first event
      exp_list[0] = 32'h00000001; exp_list[1] = 32'h00000002;
      step_val[0] = 32'h00000001; step_hold[0] = 3; nsteps = 1;
      load_list(2);
      do_run(2, '0, 1'b0);

      // empty run, then a run with ignored write/start, then a rerun on the retained list
      do_run(0, 32'h12345678, 1'b0);
      plan_list();
      load_list(5);
      do_run(5, '0, 1'b1);
      plan_list();
      do_run(5, '0, 1'b0);

      // reset mid-run after two matched events
      gpio = '0; num_checks = 6'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      gpio = 32'hFFFFFFFF;
      repeat (3) begin @(posedge clk); #1; end
      gpio = 32'h00000001;
      repeat (2) begin @(posedge clk); #1; end
      check("mid_busy_before_reset", 64'(busy), 64'd1);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_done", 64'(done), 64'd0);
      check("mid_rst_pass", 64'(pass), 64'd0);
      check("mid_rst_fail", 64'(fail), 64'd0);
      check("mid_rst_state", 64'(dbg_state), 64'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      plan_list();
      do_run(5, '0, 1'b0);

      // full-depth run with gpio changing every cycle
      for (int i = 0; i < DEPTH; i++) begin
         exp_list[i] = 32'hA5000000 + 32'(i) * 32'h00010003;
         step_val[i] = exp_list[i]; step_hold[i] = 1;
      end
      nsteps = DEPTH;
      load_list(DEPTH);
      do_run(DEPTH, '0, 1'b0);

`ifdef GPIO_CHECKER_MASK_EN
      exp_list[0] = 32'h00FF0000; mask_list[0] = 32'h00FF0000;
      step_val[0] = 32'h12FF3456; step_hold[0] = 2; nsteps = 1;
      load_list(1);
      do_run(1, '0, 1'b0);
      mask_list[0] = 32'hFFFFFFFF;
      load_list(1);
      do_run(1, '0, 1'b0);
`endif

      for (int t = 0; t < 30; t++) random_run();

      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      report();
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      miscompares++;
      report();
   end

endmodule
